// File: rtl/mdio_mgr_pkg.sv
// Shared constants, init-table entry type and FSM encoding
// for the MDIO PHY manager.
package mdio_mgr_pkg;

  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;

  localparam logic [4:0] REG_BMCR = 5'h00;
  localparam logic [4:0] REG_BMSR = 5'h01;
  localparam logic [4:0] REG_GBCR = 5'h09;

  localparam logic [15:0] BMCR_ANEG_RESTART = 16'h1340;
  localparam logic [15:0] GBCR_NO_1G = 16'h0000;

  localparam int BMSR_LINK_BIT = 2;
  localparam int INIT_IDX_W = 2;

  typedef enum logic [3:0] {
    DELAY,
    INIT_ISSUE,
    INIT_WAIT,
    IDLE,
    HOST_ISSUE,
    HOST_WR_WAIT,
    HOST_RD_WAIT,
    POLL_ISSUE,
    POLL_RD_WAIT
  } mgr_state_e;

  typedef struct packed {
    logic [4:0] reg_addr;
    logic [15:0] data;
    logic last;
  } init_entry_t;

endpackage

// File: rtl/mdio_mgr_init_rom.sv
// PHY init table: optional 1000BASE-T advert disable,
// then auto-negotiation restart.
module mdio_mgr_init_rom
  import mdio_mgr_pkg::*;
#(
  parameter bit DISABLE_1G = 1'b1
) (
  input logic [INIT_IDX_W-1:0] idx,
  output init_entry_t entry
);

  always_comb begin
    entry = '{
      reg_addr: REG_BMCR,
      data: BMCR_ANEG_RESTART,
      last: 1'b1
    };
    if (DISABLE_1G && idx == '0) begin
      entry = '{
        reg_addr: REG_GBCR,
        data: GBCR_NO_1G,
        last: 1'b0
      };
    end
  end

endmodule

// File: rtl/mdio_phy_manager.sv
// Sequences PHY init, periodic BMSR polling and host
// commands onto a single shared mdio_master.
module mdio_phy_manager
  import mdio_mgr_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'h00,
  parameter logic [19:0] INIT_DELAY = 20'hFFFFF,
  parameter int POLL_INTERVAL = 1_250_000,
  parameter bit DISABLE_1G = 1'b1
) (
  input logic clk,
  input logic rst,

  input logic [4:0] host_cmd_reg_addr,
  input logic [15:0] host_cmd_data,
  input logic [1:0] host_cmd_opcode,
  input logic host_cmd_valid,
  output logic host_cmd_ready,
  output logic [15:0] host_rsp_data,
  output logic host_rsp_valid,

  output logic [4:0] mdio_cmd_phy_addr,
  output logic [4:0] mdio_cmd_reg_addr,
  output logic [15:0] mdio_cmd_data,
  output logic [1:0] mdio_cmd_opcode,
  output logic mdio_cmd_valid,
  input logic mdio_cmd_ready,
  input logic [15:0] mdio_data_out,
  input logic mdio_data_out_valid,
  output logic mdio_data_out_ready,

  output logic init_done,
  output logic link_up,
  output logic link_change
);

  localparam int PW = $clog2(POLL_INTERVAL + 1);
  localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_INTERVAL);
  localparam logic [PW-1:0] POLL_ONE = PW'(1);

  mgr_state_e state;
  logic [19:0] delay_cnt;
  logic [PW-1:0] poll_cnt;
  logic poll_pending;
  logic [INIT_IDX_W-1:0] init_idx;
  logic [INIT_IDX_W-1:0] rom_idx;
  logic init_last;
  logic host_rd;
  logic cmd_hs;
  logic bmsr_link;
  init_entry_t rom_entry;

  // Look one entry ahead while waiting so the next
  // command can be loaded on the same edge we leave.
  assign rom_idx = (state == INIT_WAIT)
                 ? init_idx + INIT_IDX_W'(1)
                 : '0;

  mdio_mgr_init_rom #(
    .DISABLE_1G(DISABLE_1G)
  ) u_init_rom (
    .idx(rom_idx),
    .entry(rom_entry)
  );

  assign cmd_hs = mdio_cmd_valid & mdio_cmd_ready;
  assign bmsr_link = mdio_data_out[BMSR_LINK_BIT];

  assign mdio_cmd_phy_addr = PHY_ADDR;
  assign host_cmd_ready = (state == IDLE) & init_done;
  assign mdio_data_out_ready = (state == HOST_RD_WAIT)
                             | (state == POLL_RD_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DELAY;
      delay_cnt <= INIT_DELAY;
      poll_cnt <= POLL_LOAD;
      poll_pending <= 1'b0;
      init_idx <= '0;
      init_last <= 1'b0;
      host_rd <= 1'b0;
      mdio_cmd_reg_addr <= '0;
      mdio_cmd_data <= '0;
      mdio_cmd_opcode <= MDIO_OP_WR;
      mdio_cmd_valid <= 1'b0;
      host_rsp_data <= '0;
      host_rsp_valid <= 1'b0;
      init_done <= 1'b0;
      link_up <= 1'b0;
      link_change <= 1'b0;
    end else begin
      host_rsp_valid <= 1'b0;
      link_change <= 1'b0;

      unique case (state)
        DELAY: begin
          if (delay_cnt == '0) begin
            mdio_cmd_reg_addr <= rom_entry.reg_addr;
            mdio_cmd_data <= rom_entry.data;
            mdio_cmd_opcode <= MDIO_OP_WR;
            mdio_cmd_valid <= 1'b1;
            init_last <= rom_entry.last;
            init_idx <= rom_idx;
            state <= INIT_ISSUE;
          end else begin
            delay_cnt <= delay_cnt - 20'd1;
          end
        end

        INIT_ISSUE: begin
          if (cmd_hs) begin
            mdio_cmd_valid <= 1'b0;
            state <= INIT_WAIT;
          end
        end

        INIT_WAIT: begin
          if (mdio_cmd_ready) begin
            if (init_last) begin
              init_done <= 1'b1;
              poll_cnt <= POLL_LOAD;
              state <= IDLE;
            end else begin
              mdio_cmd_reg_addr <= rom_entry.reg_addr;
              mdio_cmd_data <= rom_entry.data;
              mdio_cmd_opcode <= MDIO_OP_WR;
              mdio_cmd_valid <= 1'b1;
              init_last <= rom_entry.last;
              init_idx <= rom_idx;
              state <= INIT_ISSUE;
            end
          end
        end

        IDLE: begin
          // A single pending flag merges expiries.
          if (poll_cnt <= POLL_ONE) begin
            poll_pending <= 1'b1;
            poll_cnt <= POLL_LOAD;
          end else begin
            poll_cnt <= poll_cnt - POLL_ONE;
          end

          if (host_cmd_valid) begin
            host_rd <= (host_cmd_opcode == MDIO_OP_RD);
            mdio_cmd_reg_addr <= host_cmd_reg_addr;
            mdio_cmd_data <= host_cmd_data;
            mdio_cmd_opcode <= (host_cmd_opcode == MDIO_OP_RD)
                             ? MDIO_OP_RD : MDIO_OP_WR;
            mdio_cmd_valid <= 1'b1;
            state <= HOST_ISSUE;
          end else if (poll_pending && mdio_cmd_ready) begin
            mdio_cmd_reg_addr <= REG_BMSR;
            mdio_cmd_data <= '0;
            mdio_cmd_opcode <= MDIO_OP_RD;
            mdio_cmd_valid <= 1'b1;
            state <= POLL_ISSUE;
          end
        end

        HOST_ISSUE: begin
          if (cmd_hs) begin
            mdio_cmd_valid <= 1'b0;
            state <= host_rd ? HOST_RD_WAIT : HOST_WR_WAIT;
          end
        end

        HOST_WR_WAIT: begin
          if (mdio_cmd_ready) begin
            state <= IDLE;
          end
        end

        HOST_RD_WAIT: begin
          if (mdio_data_out_valid) begin
            host_rsp_data <= mdio_data_out;
            host_rsp_valid <= 1'b1;
            state <= IDLE;
          end
        end

        POLL_ISSUE: begin
          if (cmd_hs) begin
            mdio_cmd_valid <= 1'b0;
            poll_pending <= 1'b0;
            state <= POLL_RD_WAIT;
          end
        end

        POLL_RD_WAIT: begin
          if (mdio_data_out_valid) begin
            link_up <= bmsr_link;
            link_change <= bmsr_link ^ link_up;
            state <= IDLE;
          end
        end

        default: begin
          state <= DELAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_phy_manager.sv
// Directed bench: managers with and without the 1G disable,
// each driving a behavioural 40-cycle MDIO master model.
module tb_mdio_phy_manager;
  import mdio_mgr_pkg::*;

  localparam logic [5:0] TX_LAT = 6'd40;
  localparam logic [15:0] PHYID1 = 16'h0141;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  logic [15:0] bmsr;
  logic [4:0] h_reg;
  logic [15:0] h_data;
  logic [1:0] h_op;
  logic h_valid;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_mgr
    logic [4:0] phy, ra;
    logic [15:0] wd;
    logic [1:0] op;
    logic vld, hrdy, rspv, dor, idone, lup, lchg;
    logic [15:0] rsp;
    logic rdy, dov, rd_pend, pv;
    logic [15:0] dout;
    logic [5:0] busy;
    logic [4:0] rreg;
    logic [22:0] pcmd;
    int tx_n = 0;
    int dh_cyc = 0;
    int wr_cyc = 0;
    int rd1_n = 0;
    int viol = 0;
    logic [4:0] tx_reg[64];
    logic [15:0] tx_data[64];
    logic [1:0] tx_op[64];
    int tx_cyc[64];

    mdio_phy_manager #(
      .PHY_ADDR(5'h00),
      .INIT_DELAY(20'd16),
      .POLL_INTERVAL(100),
      .DISABLE_1G(1'(g == 1))
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .host_cmd_reg_addr(h_reg),
      .host_cmd_data(h_data),
      .host_cmd_opcode(h_op),
      .host_cmd_valid((g == 1) ? h_valid : 1'b0),
      .host_cmd_ready(hrdy),
      .host_rsp_data(rsp),
      .host_rsp_valid(rspv),
      .mdio_cmd_phy_addr(phy),
      .mdio_cmd_reg_addr(ra),
      .mdio_cmd_data(wd),
      .mdio_cmd_opcode(op),
      .mdio_cmd_valid(vld),
      .mdio_cmd_ready(rdy),
      .mdio_data_out(dout),
      .mdio_data_out_valid(dov),
      .mdio_data_out_ready(dor),
      .init_done(idone),
      .link_up(lup),
      .link_change(lchg)
    );

    always @(posedge clk) begin
      if (rst) begin
        rdy <= 1'b1;
        dov <= 1'b0;
        dout <= '0;
        busy <= '0;
        rd_pend <= 1'b0;
        rreg <= '0;
        pv <= 1'b0;
        pcmd <= '0;
      end else begin
        pv <= vld & ~rdy;
        pcmd <= {ra, wd, op};
        if (pv && (!vld || {ra, wd, op} != pcmd)) viol <= viol + 1;
        if (vld && rdy) begin
          rdy <= 1'b0;
          busy <= TX_LAT;
          rd_pend <= (op == MDIO_OP_RD);
          rreg <= ra;
          if (tx_n < 64) begin
            tx_reg[tx_n[5:0]] <= ra;
            tx_data[tx_n[5:0]] <= wd;
            tx_op[tx_n[5:0]] <= op;
            tx_cyc[tx_n[5:0]] <= cyc;
          end
          tx_n <= tx_n + 1;
        end else if (busy > 6'd1) begin
          busy <= busy - 6'd1;
        end else if (busy == 6'd1) begin
          busy <= '0;
          if (rd_pend) begin
            dov <= 1'b1;
            dout <= (rreg == REG_BMSR) ? bmsr
                  : (rreg == 5'h02) ? PHYID1 : 16'h0000;
          end else begin
            rdy <= 1'b1;
            wr_cyc <= cyc;
          end
        end
        if (dov && dor) begin
          dov <= 1'b0;
          rdy <= 1'b1;
          dh_cyc <= cyc;
          if (rreg == REG_BMSR) rd1_n <= rd1_n + 1;
        end
      end
    end
  end

  int lc_cnt = 0, lc_wide = 0, rsp_wide = 0;
  logic lc_q = 1'b0, rsp_q = 1'b0;
  always @(negedge clk) begin
    if (g_mgr[1].lchg) begin
      lc_cnt += 1;
      if (lc_q) lc_wide += 1;
    end
    if (g_mgr[1].rspv && rsp_q) rsp_wide += 1;
    lc_q = g_mgr[1].lchg;
    rsp_q = g_mgr[1].rspv;
  end

  task automatic check_reset_outs(input string tag);
    check({tag, "_cmd1"},
          {g_mgr[1].vld, g_mgr[1].op, g_mgr[1].ra, g_mgr[1].wd},
          {1'b0, MDIO_OP_WR, 5'h00, 16'h0000});
    check({tag, "_sts1"},
          {g_mgr[1].phy, g_mgr[1].hrdy, g_mgr[1].rspv, g_mgr[1].dor,
           g_mgr[1].idone, g_mgr[1].lup, g_mgr[1].lchg, g_mgr[1].rsp},
          {5'h00, 6'b000000, 16'h0000});
    check({tag, "_cmd0"},
          {g_mgr[0].vld, g_mgr[0].op, g_mgr[0].ra, g_mgr[0].wd},
          {1'b0, MDIO_OP_WR, 5'h00, 16'h0000});
    check({tag, "_sts0"},
          {g_mgr[0].phy, g_mgr[0].hrdy, g_mgr[0].rspv, g_mgr[0].dor,
           g_mgr[0].idone, g_mgr[0].lup, g_mgr[0].lchg, g_mgr[0].rsp},
          {5'h00, 6'b000000, 16'h0000});
  endtask

  initial begin
    int n, early, init_cyc, rsp_cyc, lc_base, base;
    h_valid = 1'b1;
    h_reg = 5'h04;
    h_data = 16'h01E1;
    h_op = MDIO_OP_WR;
    bmsr = 16'h796D;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs("rst0");
    rst = 1'b0;

    early = 0;
    n = 0;
    while (!g_mgr[1].idone && n < 400) begin
      @(negedge clk);
      n++;
      if (g_mgr[1].hrdy && !g_mgr[1].idone) early++;
    end
    init_cyc = cyc;
    check("init_done", 32'(g_mgr[1].idone), 1);
    check("host_rdy_early", early, 0);
    check("host_rdy_1st_idle", 32'(g_mgr[1].hrdy), 1);
    check("init_tx_n", g_mgr[1].tx_n, 2);
    check("init_after_wr", init_cyc, g_mgr[1].wr_cyc + 2);
    check("init0", {g_mgr[1].tx_reg[0], g_mgr[1].tx_data[0], g_mgr[1].tx_op[0]},
          {REG_GBCR, 16'h0000, MDIO_OP_WR});
    check("init0_cyc", g_mgr[1].tx_cyc[0], 17);
    check("init1", {g_mgr[1].tx_reg[1], g_mgr[1].tx_data[1], g_mgr[1].tx_op[1]},
          {REG_BMCR, 16'h1340, MDIO_OP_WR});
    check("no1g_done", 32'(g_mgr[0].idone), 1);
    check("no1g_tx_n", g_mgr[0].tx_n, 1);
    check("no1g_init0", {g_mgr[0].tx_reg[0], g_mgr[0].tx_data[0], g_mgr[0].tx_op[0]},
          {REG_BMCR, 16'h1340, MDIO_OP_WR});
    check("no1g_init0_cyc", g_mgr[0].tx_cyc[0], 17);
    @(posedge clk);
    #1 h_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("host_wr", {g_mgr[1].tx_reg[2], g_mgr[1].tx_data[2], g_mgr[1].tx_op[2]},
          {5'h04, 16'h01E1, MDIO_OP_WR});
    check("host_wr_cyc", g_mgr[1].tx_cyc[2], init_cyc + 1);

    n = 0;
    while (!g_mgr[1].lchg && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("lc_up_seen", 32'(g_mgr[1].lchg), 1);
    check("link_up1", 32'(g_mgr[1].lup), 1);
    check("lc_up_lat", cyc, g_mgr[1].dh_cyc + 1);
    bmsr = 16'h7969;
    @(negedge clk);
    n = 0;
    while (!g_mgr[1].lchg && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("lc_dn_seen", 32'(g_mgr[1].lchg), 1);
    check("link_up0", 32'(g_mgr[1].lup), 0);
    check("lc_dn_lat", cyc, g_mgr[1].dh_cyc + 1);
    @(negedge clk);
    lc_base = lc_cnt;
    base = g_mgr[1].rd1_n;
    n = 0;
    while (g_mgr[1].rd1_n == base && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("poll_repeat_done", g_mgr[1].rd1_n, base + 1);
    check("lc_repeat_none", lc_cnt, lc_base);
    check("link_up_hold", 32'(g_mgr[1].lup), 0);

    bmsr = 16'h796D;
    n = 0;
    while (!(g_mgr[1].u_dut.poll_pending && g_mgr[1].hrdy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("pend_idle_seen", 32'(g_mgr[1].hrdy), 1);
    base = g_mgr[1].tx_n;
    h_reg = 5'h02;
    h_data = 16'hABCD;
    h_op = MDIO_OP_RD;
    h_valid = 1'b1;
    @(posedge clk);
    #1 h_valid = 1'b0;
    n = 0;
    while (!g_mgr[1].rspv && n < 200) begin
      @(negedge clk);
      n++;
    end
    rsp_cyc = cyc;
    check("rsp_seen", 32'(g_mgr[1].rspv), 1);
    check("rsp_data", 32'(g_mgr[1].rsp), 32'(PHYID1));
    check("rsp_lat", rsp_cyc, g_mgr[1].dh_cyc + 1);
    @(negedge clk);
    check("rsp_pulse", 32'(g_mgr[1].rspv), 0);
    repeat (3) @(negedge clk);
    check("host_first", {g_mgr[1].tx_reg[base[5:0]], g_mgr[1].tx_op[base[5:0]]},
          {5'h02, MDIO_OP_RD});
    check("poll_next", {g_mgr[1].tx_reg[6'(base + 1)], g_mgr[1].tx_op[6'(base + 1)]},
          {REG_BMSR, MDIO_OP_RD});
    check("poll_next_cyc", g_mgr[1].tx_cyc[6'(base + 1)], rsp_cyc + 1);

    n = 0;
    while (!g_mgr[1].lup && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("link_up_again", 32'(g_mgr[1].lup), 1);
    @(negedge clk);
    n = 0;
    while (!g_mgr[1].dor && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("in_poll_rd_wait", {g_mgr[1].dor, g_mgr[1].rreg}, {1'b1, REG_BMSR});
    rst = 1'b1;
    @(negedge clk);
    check_reset_outs("rst1");
    rst = 1'b0;
    base = g_mgr[1].tx_n;
    n = 0;
    while (!g_mgr[1].idone && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("reinit_done", 32'(g_mgr[1].idone), 1);
    check("reinit_tx_n", g_mgr[1].tx_n - base, 2);
    check("reinit0", {g_mgr[1].tx_reg[base[5:0]], g_mgr[1].tx_data[base[5:0]]},
          {REG_GBCR, 16'h0000});
    check("reinit0_cyc", g_mgr[1].tx_cyc[base[5:0]], 17);
    check("reinit1", {g_mgr[1].tx_reg[6'(base + 1)], g_mgr[1].tx_data[6'(base + 1)]},
          {REG_BMCR, 16'h1340});

    check("lc_pulse_width", lc_wide, 0);
    check("rsp_pulse_width", rsp_wide, 0);
    check("cmd_stable1", g_mgr[1].viol, 0);
    check("cmd_stable0", g_mgr[0].viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
